// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider, one shift-subtract step per clock, runtime signed/unsigned.
// Quotient goes to LOOut, remainder to HIOut; divide-by-zero reports Div0 one edge after start.
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             DivCtrl,
  input  logic             Signed,
  input  logic [WIDTH-1:0] FromA,
  input  logic [WIDTH-1:0] FromB,
  output logic             Busy,
  output logic             Done,
  output logic             Div0,
  output logic [WIDTH-1:0] HIOut,
  output logic [WIDTH-1:0] LOOut
);

  localparam int CW = $clog2(WIDTH);

  // state | meaning
  // IDLE  | waiting for DivCtrl; also finishes a pending divide-by-zero
  // CALC  | one restoring step per edge, WIDTH steps
  // FIX   | apply signs to quotient/remainder, pulse Done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             qneg;
  logic             rneg;
  logic             div0_pend;
  logic             start;
  logic             last;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign start = (state == IDLE) && DivCtrl && !div0_pend;
  assign last  = (count == CW'(WIDTH - 1));
  assign Busy  = (state != IDLE);

  // dvd shifts dividend bits out of the top and quotient bits in at the bottom
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (FromB != '0)) state_nxt = CALC;
      CALC:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count     <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      div0_pend <= 1'b0;
      Done      <= 1'b0;
      Div0      <= 1'b0;
      HIOut     <= '0;
      LOOut     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (div0_pend) begin
            div0_pend <= 1'b0;
            Div0      <= 1'b1;
            Done      <= 1'b1;
            HIOut     <= '0;
            LOOut     <= '0;
          end else if (start) begin
            Div0      <= 1'b0;
            div0_pend <= (FromB == '0);
            dvd       <= mag(FromA, Signed);
            dvs       <= mag(FromB, Signed);
            qneg      <= Signed & (FromA[WIDTH-1] ^ FromB[WIDTH-1]);
            rneg      <= Signed & FromA[WIDTH-1];
            rem       <= '0;
            count     <= '0;
          end
        end
        CALC: begin
          rem   <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
          count <= count + 1'b1;
        end
        FIX: begin
          LOOut <= qneg ? -dvd : dvd;
          HIOut <= rneg ? -rem : rem;
          Done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param: a 32-bit instance for arithmetic/handshake cases,
// an 8-bit instance for back-to-back operation with DivCtrl held high.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl = 1'b0, sgn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  logic        ctrl8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, div08;
  logic [7:0]  hi8, lo8;

  int checks = 0, passes = 0, fails = 0;
  int lat, bn, cnt;
  logic b0;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(32)) dut32 (
    .Clock(clk), .Reset(rst), .DivCtrl(ctrl), .Signed(sgn), .FromA(a), .FromB(b),
    .Busy(busy), .Done(done), .Div0(div0), .HIOut(hi), .LOOut(lo));

  div_seq_param #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset(rst), .DivCtrl(ctrl8), .Signed(1'b0), .FromA(a8), .FromB(b8),
    .Busy(busy8), .Done(done8), .Div0(div08), .HIOut(hi8), .LOOut(lo8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] da, input logic [31:0] db, input logic ds);
    @(negedge clk);
    ctrl = 1'b1; a = da; b = db; sgn = ds;
    @(posedge clk); #1;
    ctrl = 1'b0;
  endtask

  // edges until Done (bounded), plus count of sampled cycles with Busy high
  task automatic wait_done(output int l, output int bcnt);
    l = 0; bcnt = 0;
    while (!done && l < 100) begin
      @(posedge clk); #1;
      l++;
      if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input logic [31:0] da, input logic [31:0] db, input logic ds,
                       output int l, output int bcnt);
    logic bs;
    start_op(da, db, ds);
    bs = busy;
    wait_done(l, bcnt);
    bcnt += int'(bs);
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div0", {31'd0, div0}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, lat, bn);
    check("u100_7_lat", lat, 32'd33);
    check("u100_7_busy", bn, 32'd33);
    check("u100_7_lo", lo, 32'd14);
    check("u100_7_hi", hi, 32'd2);
    check("u100_7_div0", {31'd0, div0}, 32'd0);
    check("u100_7_busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("u100_7_done_pulse", {31'd0, done}, 32'd0);
    check("u100_7_lo_hold", lo, 32'd14);

    do_op(-32'sd7, 32'd2, 1'b1, lat, bn);
    check("sm7_2_lo", lo, 32'hFFFFFFFD);
    check("sm7_2_hi", hi, 32'hFFFFFFFF);
    do_op(32'd7, -32'sd2, 1'b1, lat, bn);
    check("s7_m2_lo", lo, 32'hFFFFFFFD);
    check("s7_m2_hi", hi, 32'd1);
    do_op(-32'sd7, -32'sd2, 1'b1, lat, bn);
    check("sm7_m2_lo", lo, 32'd3);
    check("sm7_m2_hi", hi, 32'hFFFFFFFF);

    do_op(32'hFFFFFFFF, 32'd1, 1'b0, lat, bn);
    check("umax_1_lo", lo, 32'hFFFFFFFF);
    check("umax_1_hi", hi, 32'd0);
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bn);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'd0);
    do_op(32'd5, 32'd9, 1'b0, lat, bn);
    check("u5_9_lo", lo, 32'd0);
    check("u5_9_hi", hi, 32'd5);

    do_op(32'd123, 32'd0, 1'b0, lat, bn);
    check("dz_lat", lat, 32'd1);
    check("dz_busy", bn, 32'd0);
    check("dz_div0", {31'd0, div0}, 32'd1);
    check("dz_hi", hi, 32'd0);
    check("dz_lo", lo, 32'd0);
    @(posedge clk); #1;
    check("dz_div0_hold", {31'd0, div0}, 32'd1);
    check("dz_done_pulse", {31'd0, done}, 32'd0);

    start_op(32'd10, 32'd3, 1'b0);
    check("dz_clear", {31'd0, div0}, 32'd0);
    wait_done(lat, bn);
    check("u10_3_lat", lat, 32'd33);
    check("u10_3_lo", lo, 32'd3);
    check("u10_3_hi", hi, 32'd1);

    start_op(32'd1000, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_hi", hi, 32'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("abort_no_done", cnt, 32'd0);
    do_op(32'd9, 32'd3, 1'b0, lat, bn);
    check("u9_3_lat", lat, 32'd33);
    check("u9_3_lo", lo, 32'd3);
    check("u9_3_hi", hi, 32'd0);

    start_op(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); ctrl = 1'b1; a = 32'd50; b = 32'd5;
    @(negedge clk); ctrl = 1'b0;
    wait_done(lat, bn);
    check("ign_lat", lat, 32'd27);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);

    @(negedge clk);
    ctrl8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(posedge clk); #1;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_lat1", lat, 32'd9);
    check("w8_lo1", {24'd0, lo8}, 32'd14);
    check("w8_hi1", {24'd0, hi8}, 32'd2);
    @(negedge clk); a8 = 8'd200; b8 = 8'd9;
    @(posedge clk); #1;
    check("w8_done_pulse", {31'd0, done8}, 32'd0);
    check("w8_restart_busy", {31'd0, busy8}, 32'd1);
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_lat2", lat, 32'd9);
    check("w8_lo2", {24'd0, lo8}, 32'd22);
    check("w8_hi2", {24'd0, hi8}, 32'd2);
    @(negedge clk); ctrl8 = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
